// File: rtl/charlieplex_pkg.sv
// charlieplex_pkg: CTRL register map and row-to-pin mapping shared by the charlieplex driver
package charlieplex_pkg;
  localparam logic [7:0] CTRL_ADR = 8'hFF;
  localparam int CTRL_EN = 0;
  localparam int CTRL_SWAP = 1;
  localparam int CTRL_FRONT = 2;
  function automatic int row_pin(input int row, input int col);
    return (row < col) ? row : row + 1;
  endfunction
endpackage

// File: rtl/charlieplex_scan.sv
// charlieplex_scan: prescaled tick driving pwm -> row -> col scan counters with frame-end strobe
module charlieplex_scan #(
  parameter int CLK_HZ = 12000000,
  parameter int TICK_HZ = 1000000,
  parameter int ROWS = 5,
  parameter int COLS = 7,
  parameter int LVL_W = 4,
  parameter int RW = 3,
  parameter int CW = 3
) (
  input  logic             clk,
  input  logic             rst,
  output logic [RW-1:0]    row,
  output logic [CW-1:0]    col,
  output logic [LVL_W-1:0] pwm,
  output logic             frame_end
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PSW = $clog2(DIV);
  logic [PSW-1:0] ps_q, ps_d;
  logic [LVL_W-1:0] pwm_q, pwm_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic tick, pwm_wrap, row_wrap;
  always_comb begin
    tick = ps_q == PSW'(DIV - 1);
    pwm_wrap = tick & (pwm_q == '1);
    row_wrap = pwm_wrap & (row_q == RW'(ROWS - 1));
    frame_end = row_wrap & (col_q == CW'(COLS - 1));
    ps_d = tick ? '0 : ps_q + 1'b1;
    pwm_d = tick ? pwm_q + 1'b1 : pwm_q;
    row_d = row_wrap ? '0 : pwm_wrap ? row_q + 1'b1 : row_q;
    col_d = frame_end ? '0 : row_wrap ? col_q + 1'b1 : col_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q <= '0;
      pwm_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      ps_q <= ps_d;
      pwm_q <= pwm_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end
  assign row = row_q;
  assign col = col_q;
  assign pwm = pwm_q;
endmodule

// File: rtl/charlieplex_pwm.sv
// charlieplex_pwm: double-buffered PWM charlieplex LED driver with a Wishbone-style pixel/CTRL port
module charlieplex_pwm
  import charlieplex_pkg::*;
#(
  parameter int CLK_HZ = 12000000,
  parameter int TICK_HZ = 1000000,
  parameter int PINS = 7,
  parameter int ROWS = 5,
  parameter int COLS = 7,
  parameter int LVL_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_stb,
  input  logic            wb_we,
  input  logic [7:0]      wb_adr,
  input  logic [7:0]      wb_dat_i,
  output logic [7:0]      wb_dat_o,
  output logic            wb_ack,
  output logic [PINS-1:0] pin_o,
  output logic [PINS-1:0] pin_oe,
  output logic            frame_o
);
  localparam int PIX = ROWS * COLS;
  localparam int AW = PIX > 1 ? $clog2(PIX) : 1;
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int PW = PINS > 1 ? $clog2(PINS) : 1;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [LVL_W-1:0] pwm;
  logic frame_end;
  logic [LVL_W-1:0] bank_q [2][PIX];
  logic en_q, en_d, pend_q, pend_d, front_q, front_d, ack_q, ack_d, frame_q;
  logic [7:0] dat_q, dat_d, ctrl_rd;
  logic [PINS-1:0] o_q, o_d, oe_q, oe_d;
  logic acc, is_ctrl, is_pix, pix_wr, ctrl_wr, swap_req, lit;
  logic [AW-1:0] pix_adr, idx;
  logic [LVL_W-1:0] level;
  logic [PW-1:0] rp, cp;
  logic unused_dat;
  assign unused_dat = ^wb_dat_i;
  charlieplex_scan #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .ROWS(ROWS), .COLS(COLS),
    .LVL_W(LVL_W), .RW(RW), .CW(CW)
  ) u_scan (
    .clk(clk), .rst(rst), .row(row), .col(col), .pwm(pwm), .frame_end(frame_end)
  );
  always_comb begin
    acc = wb_stb & ~ack_q;
    is_ctrl = wb_adr == CTRL_ADR;
    is_pix = int'(wb_adr) < PIX;
    pix_adr = AW'(wb_adr);
    pix_wr = acc & wb_we & is_pix & ~rst;
    ctrl_wr = acc & wb_we & is_ctrl;
    // a request landing in the frame-end cycle is honoured at that same frame end
    swap_req = pend_q | (ctrl_wr & wb_dat_i[CTRL_SWAP]);
    en_d = ctrl_wr ? wb_dat_i[CTRL_EN] : en_q;
    pend_d = swap_req & ~frame_end;
    front_d = front_q ^ (swap_req & frame_end);
    ack_d = acc;
    ctrl_rd = '0;
    ctrl_rd[CTRL_EN] = en_q;
    ctrl_rd[CTRL_SWAP] = pend_q;
    ctrl_rd[CTRL_FRONT] = front_q;
    dat_d = !acc ? 8'd0 : is_ctrl ? ctrl_rd : is_pix ? 8'(bank_q[~front_q][pix_adr]) : 8'd0;
    idx = AW'(int'(row) * COLS + int'(col));
    level = bank_q[front_q][idx];
    lit = en_q & (pwm < level);
    rp = PW'(row_pin(int'(row), int'(col)));
    cp = PW'(col);
    o_d = lit ? PINS'(1) << rp : '0;
    oe_d = lit ? o_d | (PINS'(1) << cp) : '0;
  end
  // write targets the pre-swap back bank even when a swap lands on the same edge
  always_ff @(posedge clk) begin
    if (pix_wr) bank_q[~front_q][pix_adr] <= wb_dat_i[LVL_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q <= 1'b0;
      pend_q <= 1'b0;
      front_q <= 1'b0;
      ack_q <= 1'b0;
      dat_q <= '0;
      o_q <= '0;
      oe_q <= '0;
      frame_q <= 1'b0;
    end else begin
      en_q <= en_d;
      pend_q <= pend_d;
      front_q <= front_d;
      ack_q <= ack_d;
      dat_q <= dat_d;
      o_q <= o_d;
      oe_q <= oe_d;
      frame_q <= frame_end;
    end
  end
  assign wb_ack = ack_q;
  assign wb_dat_o = dat_q;
  assign pin_o = o_q;
  assign pin_oe = oe_q;
  assign frame_o = frame_q;
endmodule

// File: tb/tb_charlieplex_pwm.sv
// tb_charlieplex_pwm: directed bus/scan tests with a queued read scoreboard checked on wb_ack
module tb_charlieplex_pwm;
  localparam int FRAME = 5 * 7 * 16 * 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wb_stb = 1'b0;
  logic wb_we = 1'b0;
  logic [7:0] wb_adr = '0;
  logic [7:0] wb_dat_i = '0;
  logic [7:0] wb_dat_o;
  logic wb_ack;
  logic [6:0] pin_o, pin_oe;
  logic frame_o;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [8:0] exp_q [$];
  string name_q [$];
  logic [8:0] mon_e;
  string mon_n;
  logic [3:0] bank_m [2][35];
  logic front_m, pend_m, en_m;
  int t0, nz, lit_n;
  logic [13:0] pe;
  charlieplex_pwm #(
    .CLK_HZ(2), .TICK_HZ(1), .PINS(7), .ROWS(5), .COLS(7), .LVL_W(4)
  ) dut (
    .clk(clk), .rst(rst), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
    .pin_o(pin_o), .pin_oe(pin_oe), .frame_o(frame_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (wb_ack === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_ack", exp_q.size(), 1);
      else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        if (mon_e[8]) check(mon_n, wb_dat_o, mon_e[7:0]);
      end
    end
  end
  task automatic bus(input logic we, input logic [7:0] adr, input logic [7:0] dat,
                     input logic chk, input logic [7:0] exp, input string n);
    @(negedge clk);
    exp_q.push_back({chk, exp});
    name_q.push_back(n);
    wb_stb = 1'b1;
    wb_we = we;
    wb_adr = adr;
    wb_dat_i = dat;
    if (we && adr < 8'd35) bank_m[!front_m][adr] = dat[3:0];
    @(negedge clk);
    check({n, "_ack"}, wb_ack, 1);
    wb_stb = 1'b0;
    wb_we = 1'b0;
    @(negedge clk);
    check({n, "_ack_end"}, wb_ack, 0);
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus(1'b1, a, d, 1'b0, 8'h00, "wr");
  endtask
  task automatic rd(input logic [7:0] a, input logic [7:0] e, input string n);
    bus(1'b0, a, 8'h00, 1'b1, e, n);
  endtask
  task automatic wait_frame(input string n);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_o !== 1'b1 && k < 3000);
    check({n, "_frame_seen"}, frame_o, 1);
    if (frame_o === 1'b1) begin
      front_m = front_m ^ pend_m;
      pend_m = 1'b0;
    end
  endtask
  function automatic logic [13:0] pins_exp(input int k);
    int p, pw, c, r, rp;
    logic [3:0] lv;
    p = k / 32;
    pw = (k % 32) / 2;
    c = p / 5;
    r = p % 5;
    lv = bank_m[front_m][r * 7 + c];
    rp = r < c ? r : r + 1;
    if (en_m && pw < int'(lv)) return {7'(1 << rp) | 7'(1 << c), 7'(1 << rp)};
    return '0;
  endfunction
  initial begin
    front_m = 1'b0;
    pend_m = 1'b0;
    en_m = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pin_oe", pin_oe, 0);
    check("rst_pin_o", pin_o, 0);
    check("rst_frame_o", frame_o, 0);
    check("rst_ack", wb_ack, 0);
    check("rst_dat_o", wb_dat_o, 0);
    rst = 1'b0;
    rd(8'hFF, 8'h00, "ctrl_rst");
    for (int a = 0; a < 35; a++) wr(8'(a), 8'h00);
    wr(8'hFF, 8'h02);
    pend_m = 1'b1;
    rd(8'hFF, 8'h02, "ctrl_pending");
    wait_frame("init_swap");
    rd(8'hFF, 8'h04, "ctrl_front1");
    for (int a = 0; a < 35; a++) wr(8'(a), 8'h00);
    wr(8'd8, 8'h05);
    rd(8'd8, 8'h05, "pix8_rd");
    rd(8'h40, 8'h00, "unmapped_rd");
    wr(8'h40, 8'hAA);
    rd(8'h40, 8'h00, "unmapped_wr");
    wr(8'd34, 8'hF9);
    rd(8'd34, 8'h09, "pix34_trunc");
    wr(8'd35, 8'h07);
    rd(8'd35, 8'h00, "adr35_unmapped");
    rd(8'd0, 8'h00, "pix0_rd");
    wr(8'hFF, 8'h01);
    en_m = 1'b1;
    wait_frame("blank_sync");
    t0 = cyc;
    nz = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (pin_oe !== 7'd0) nz++;
      if (frame_o === 1'b1) break;
    end
    check("blank_oe_cycles", nz, 0);
    check("frame_period", cyc - t0, FRAME);
    repeat (1116) @(negedge clk);
    wr(8'hFF, 8'h03);
    pend_m = 1'b1;
    check("pre_swap_frame_o", frame_o, 0);
    @(negedge clk);
    check("swap_frame_o", frame_o, 1);
    front_m = front_m ^ pend_m;
    pend_m = 1'b0;
    rd(8'hFF, 8'h01, "ctrl_after_late_swap");
    wr(8'd0, 8'h0F);
    wr(8'd1, 8'h08);
    wr(8'd8, 8'h05);
    wr(8'hFF, 8'h03);
    pend_m = 1'b1;
    wait_frame("show_swap");
    lit_n = 0;
    for (int k = 0; k < 224; k++) begin
      @(negedge clk);
      pe = pins_exp(k);
      check("scan_pin_oe", pin_oe, pe[13:7]);
      check("scan_pin_o", pin_o, pe[6:0]);
      if (k < 32 && pin_oe === 7'b0000011 && pin_o === 7'b0000010) lit_n++;
    end
    check("pix0_lit_cycles", lit_n, 30);
    wait_frame("rst_sync");
    @(negedge clk);
    check("pre_rst_oe", pin_oe, 7'b0000011);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_pin_oe", pin_oe, 0);
    check("mid_rst_pin_o", pin_o, 0);
    check("mid_rst_frame_o", frame_o, 0);
    rst = 1'b0;
    t0 = cyc;
    front_m = 1'b0;
    en_m = 1'b0;
    pend_m = 1'b0;
    rd(8'hFF, 8'h00, "ctrl_after_rst");
    nz = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (pin_oe !== 7'd0) nz++;
      if (frame_o === 1'b1) break;
    end
    check("post_rst_oe_cycles", nz, 0);
    check("rst_restart_period", cyc - t0, FRAME);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/charlieplex_pwm.md
CHARLIEPLEX_PWM -- requirements
Module: charlieplex_pwm

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12000000, system clock frequency.
REQ-002 SHALL have parameter TICK_HZ, default 1000000, PWM tick rate; CLK_HZ/TICK_HZ >= 2.
REQ-003 SHALL have parameter PINS, default 7, number of charlieplexed pins.
REQ-004 SHALL have parameter ROWS, default 5, rows per column, ROWS <= PINS-1.
REQ-005 SHALL have parameter COLS, default 7, columns, COLS <= PINS.
REQ-006 SHALL have parameter LVL_W, default 4, per-pixel brightness width.
REQ-007 SHALL have ports: clk in 1, system clock; rst in 1, reset, synchronous, active-high.
REQ-008 SHALL have ports: wb_stb in 1; wb_we in 1; wb_adr in 8; wb_dat_i in 8; wb_dat_o out 8; wb_ack out 1.
REQ-009 SHALL have ports: pin_o out PINS, drive level; pin_oe out PINS, drive enable; frame_o out 1, frame-end pulse.

Function
REQ-010 SHALL hold two pixel banks of ROWS*COLS entries x LVL_W bits, addressed as row*COLS+col; one is displayed (front), the other bus-accessible (back).
REQ-011 SHALL map wb_adr 0..ROWS*COLS-1 to back-bank pixels; write stores wb_dat_i[LVL_W-1:0], read returns it zero-extended.
REQ-012 SHALL map wb_adr 0xFF to CTRL: bit0 enable (R/W), bit1 swap request (W1 sets, reads 1 while pending), bit2 front bank index (RO).
REQ-013 SHALL ignore writes to unmapped addresses and return 0 on reads of them.
REQ-014 SHALL assert wb_ack exactly one cycle after a cycle with wb_stb=1 and wb_ack=0, for one cycle; wb_dat_o valid in the ack cycle; back-to-back stb yields ack every other cycle.
REQ-015 SHALL generate a one-cycle tick every CLK_HZ/TICK_HZ clocks from a free-running prescaler.
REQ-016 SHALL per tick advance pwm counter 0..2^LVL_W-1; on pwm wrap advance row 0..ROWS-1; on row wrap advance col 0..COLS-1; on col wrap end the frame.
REQ-017 SHALL light the current pixel while enable=1 and pwm counter < level; level 0 never lit, level 2^LVL_W-1 lit 15/16 of the dwell.
REQ-018 SHALL use col_pin = col and row_pin = row if row < col, else row+1.
REQ-019 SHALL when lit drive pin_oe = (1<<row_pin)|(1<<col_pin), pin_o = 1<<row_pin; otherwise pin_oe = 0, pin_o = 0.
REQ-020 SHALL register pin_o/pin_oe: outputs reflect scan state one clock after it updates.
REQ-021 SHALL at frame end pulse frame_o one cycle, and if swap pending swap banks and clear pending in that same cycle.
REQ-022 SHALL give a swap-request write coinciding with frame end effect at that frame end; a second request while pending has no extra effect.
REQ-023 SHALL, on a back-bank write coinciding with a swap, commit the write to the bank that was back before the swap.
REQ-024 SHALL, on clearing enable, blank outputs on the next tick-independent clock while scanning continues.

Reset
REQ-025 SHALL on rst clear prescaler, pwm, row, col, enable, swap pending, front index, wb_ack, wb_dat_o, pin_o, pin_oe, frame_o.
REQ-026 SHALL leave pixel banks uninitialised by rst; outputs stay blank until enable set.
REQ-027 SHALL abort any pending access on mid-operation rst; no ack issued for a stb sampled in the reset cycle.

Structure
REQ-028 SHALL place CTRL address, CTRL bit indices and the row-to-pin mapping function in package charlieplex_pkg.
REQ-029 SHALL implement prescaler/pwm/row/col counters in sub-module charlieplex_scan, outputting row, col, pwm, frame_end.
REQ-030 SHALL keep banks, Wishbone decode and pin drive in charlieplex_pwm.

Verification
REQ-031 SHALL check: write 0x0F to adr 0, set enable, swap -> after frame end pin_oe=0b0000011, pin_o=0b0000010 for 15 of 16 ticks at row 0/col 0.
REQ-032 SHALL check: write 0x05 to adr 8 (row 1, col 1), read adr 8 -> wb_dat_o=0x05 with ack one cycle after stb; read adr 0x40 -> 0.
REQ-033 SHALL check: level 0 everywhere -> pin_oe stays 0 for a full frame; frame_o pulses every ROWS*COLS*16 ticks.
REQ-034 SHALL check: swap written two cycles before frame end -> CTRL bit2 toggles at frame end, bit1 reads 0 after.
REQ-035 SHALL check: rst mid-frame with enable=1 -> next cycle pin_oe=0, CTRL reads 0, scan restarts at row 0/col 0.
